spi_slave_rx: RTL and testbench

- SPI slave endpoint that receives one DATASIZE-bit AES block (key or state) from the SPI master over sclk/scs/mosi.
- Shifts a DATASIZE-bit response block back on miso during the same frame.
- Sits on the AES core side: delivers the received block to the key-expansion/cipher input and returns the cipher output.
- Runs on the local system clock; all SPI inputs are oversampled and synchronised.

---
 rtl/spi_slave_rx.sv | 158 +++++++++++++++
 tb/tb_spi_slave_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver for one DATASIZE-bit AES block per frame.
// sclk/scs/mosi are oversampled on clk through SYNC_STAGES flops; a
// response block captured from tx_data at frame start is shifted out on miso.
// Optional build macro: SPI_SLAVE_OVERRUN_EN adds a sticky overrun flag.
//
// state | meaning
// IDLE  | waiting for synchronised scs falling edge
// SHIFT | frame in progress, sampling mosi / shifting miso
// DONE  | block delivered, waiting for scs to rise
module spi_slave_rx #(
  parameter int DATASIZE    = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                scs,
  input  logic                mosi,
  output logic                miso,
  input  logic [DATASIZE-1:0] tx_data,
  output logic [DATASIZE-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ack,
  output logic                busy,
  output logic                frame_err
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic                overrun
`endif
);

  localparam int CW = $clog2(DATASIZE + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t state, next_state;

  logic [SYNC_STAGES-1:0] sclk_pipe, scs_pipe, mosi_pipe;
  logic                   sclk_d, scs_d;
  logic                   sclk_s, scs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, scs_fall;

  logic [CW-1:0]          cnt;
  logic [DATASIZE-1:0]    rx_sr, tx_sr;
  logic                   cnt_full;

  logic                   load_tx, shift_rx, shift_tx, complete, abort;

  assign sclk_s    = sclk_pipe[SYNC_STAGES-1];
  assign scs_s     = scs_pipe[SYNC_STAGES-1];
  assign mosi_s    = mosi_pipe[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign scs_fall  = ~scs_s & scs_d;
  assign cnt_full  = (cnt == CW'(DATASIZE));

  // Synchronise SPI inputs and keep one extra sample for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_pipe <= '0;
      scs_pipe  <= '1;
      mosi_pipe <= '0;
      sclk_d    <= 1'b0;
      scs_d     <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], sclk};
      scs_pipe  <= {scs_pipe[SYNC_STAGES-2:0], scs};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      scs_d     <= scs_s;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state logic; a completed count beats a late scs rise.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (scs_fall) next_state = SHIFT;
      SHIFT:   if (cnt_full) next_state = DONE;
               else if (scs_s) next_state = IDLE;
      DONE:    if (scs_s) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-cycle control strobes decoded from state and synchronised edges.
  always_comb begin
    load_tx  = 1'b0;
    shift_rx = 1'b0;
    shift_tx = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:  load_tx = scs_fall;
      SHIFT: begin
        complete = cnt_full;
        abort    = !cnt_full && scs_s;
        shift_rx = !cnt_full && !scs_s && sclk_rise;
        shift_tx = !cnt_full && !scs_s && sclk_fall;
      end
      default: ;
    endcase
  end

  // Bit counter and shift registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      rx_sr <= '0;
      tx_sr <= '0;
    end else begin
      if (load_tx)       cnt <= '0;
      else if (shift_rx) cnt <= cnt + CW'(1);
      if (shift_rx) rx_sr <= {rx_sr[DATASIZE-2:0], mosi_s};
      if (load_tx)       tx_sr <= tx_data;
      else if (shift_tx) tx_sr <= tx_sr << 1;
    end
  end

  // miso: zero outside an active shift, else the current tx MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          miso <= 1'b0;
    else if (scs_s || state == DONE)   miso <= 1'b0;
    else if (load_tx)                  miso <= tx_data[DATASIZE-1];
    else if (shift_tx)                 miso <= tx_sr[DATASIZE-2];
  end

  // Delivery, handshake and abort reporting; a new block beats rx_ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort;
      if (complete) rx_data <= rx_sr;
      if (complete)    rx_valid <= 1'b1;
      else if (rx_ack) rx_valid <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  // Sticky flag for a block overwritten before it was acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      overrun <= 1'b0;
    else if (complete && rx_valid) overrun <= 1'b1;
    else if (rx_ack)               overrun <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx with a queue-based delivery scoreboard.
module tb_spi_slave_rx;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         sclk = 1'b0;
  logic         scs = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [127:0] tx_data = '0;
  logic [127:0] rx_data;
  logic         rx_valid;
  logic         rx_ack = 1'b0;
  logic         busy;
  logic         frame_err;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic         overrun;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] exp_q[$];

  localparam logic [127:0] BLK_A = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TX_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BLK_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BLK_C = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BLK_D = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BLK_F = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] TX_E  = 128'hdeadbeef0123456789abcdeffedcba98;

  spi_slave_rx #(.DATASIZE(128), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .scs(scs), .mosi(mosi), .miso(miso),
    .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .busy(busy), .frame_err(frame_err)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every new delivery must match the head of the queue.
  logic         prev_valid = 1'b0;
  logic [127:0] prev_data  = '0;
  initial begin
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (rst && rx_valid && (!prev_valid || rx_data != prev_data)) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rx_unexpected: got %h expected no delivery", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", rx_data, e);
        end
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic start_frame(input logic [127:0] tx);
    @(negedge clk);
    tx_data = tx;
    scs = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // mode 1: check rx_valid latency on final bit; mode 2: rx_ack collides with set
  task automatic clock_bits(input logic [127:0] blk, input int nbits, input int mode,
                            output logic [127:0] cap);
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 128) ? blk[127 - i] : 1'b0;
      repeat (4) @(negedge clk);
      if (i < 128) cap = {cap[126:0], miso};
      else check("miso_extra", {127'd0, miso}, 128'd0);
      sclk = 1'b1;
      if (i == 127 && mode == 1) begin
        repeat (3) @(negedge clk);
        check("latency_early", {127'd0, rx_valid}, 128'd0);
        @(negedge clk);
        check("latency_on", {127'd0, rx_valid}, 128'd1);
      end else if (i == 127 && mode == 2) begin
        repeat (3) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
      end else begin
        repeat (4) @(negedge clk);
      end
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk);
    scs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] cap;
    int errs;

    // Reset with scs idle.
    repeat (3) @(negedge clk);
    check("rst_miso", {127'd0, miso}, 128'd0);
    check("rst_rx_valid", {127'd0, rx_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_rx_data", rx_data, 128'd0);
    check("rst_frame_err", {127'd0, frame_err}, 128'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Full frame with latency check.
    exp_q.push_back(BLK_A);
    start_frame(TX_A);
    check("busy_start", {127'd0, busy}, 128'd1);
    clock_bits(BLK_A, 128, 1, cap);
    check("miso_A", cap, TX_A);
    check("busy_done", {127'd0, busy}, 128'd1);
    end_frame();
    check("busy_idle", {127'd0, busy}, 128'd0);

    // Handshake: ack 5 cycles after valid.
    repeat (5) @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    check("ack_clear", {127'd0, rx_valid}, 128'd0);

    // Abort after 37 bits.
    start_frame(TX_E);
    clock_bits(BLK_C, 37, 0, cap);
    repeat (4) @(negedge clk);
    scs = 1'b1;
    errs = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (frame_err) errs++;
    end
    check("frame_err_pulses", 128'(errs), 128'd1);
    check("abort_rx_data", rx_data, BLK_A);
    check("abort_rx_valid", {127'd0, rx_valid}, 128'd0);
    check("abort_busy", {127'd0, busy}, 128'd0);

    // Recovery frame.
    exp_q.push_back(BLK_D);
    start_frame(TX_E);
    clock_bits(BLK_D, 128, 0, cap);
    check("miso_E", cap, TX_E);
    end_frame();

    // Set/ack collision: rx_valid must stay high.
    exp_q.push_back(BLK_B);
    start_frame(TX_A);
    clock_bits(BLK_B, 128, 2, cap);
    end_frame();
    check("collide_valid", {127'd0, rx_valid}, 128'd1);
    pulse_ack();
    check("collide_ack", {127'd0, rx_valid}, 128'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("overrun_cleared", {127'd0, overrun}, 128'd0);
`endif

    // Back-to-back without ack.
    exp_q.push_back(BLK_C);
    start_frame(TX_A);
    clock_bits(BLK_C, 128, 0, cap);
    end_frame();
`ifdef SPI_SLAVE_OVERRUN_EN
    check("overrun_none", {127'd0, overrun}, 128'd0);
`endif
    exp_q.push_back(BLK_D);
    start_frame(TX_A);
    clock_bits(BLK_D, 128, 0, cap);
    end_frame();
    check("b2b_rx_data", rx_data, BLK_D);
    check("b2b_valid", {127'd0, rx_valid}, 128'd1);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("overrun_set", {127'd0, overrun}, 128'd1);
    repeat (3) @(negedge clk);
    check("overrun_sticky", {127'd0, overrun}, 128'd1);
`endif
    pulse_ack();
`ifdef SPI_SLAVE_OVERRUN_EN
    check("overrun_ack", {127'd0, overrun}, 128'd0);
`endif

    // 130 sclk pulses: first 128 bits kept, miso quiet afterwards.
    exp_q.push_back(BLK_F);
    start_frame(TX_E);
    clock_bits(BLK_F, 130, 0, cap);
    check("miso_F", cap, TX_E);
    end_frame();
    check("extra_rx_data", rx_data, BLK_F);
    check("extra_miso_idle", {127'd0, miso}, 128'd0);

    repeat (4) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
